// File: rtl/tinyalu_param_if.sv
// ============================================================================
// Module      : tinyalu_param_if
// Description : Operand/opcode request and result/done bundle for tinyalu_param.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tinyalu_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               busy;
    logic               done;
    logic               err;
    logic [2*WIDTH-1:0] result;

    modport master (
        output A, B, op, start,
        input  busy, done, err, result
    );

    modport slave (
        input  A, B, op, start,
        output busy, done, err, result
    );
endinterface

`default_nettype wire

// File: rtl/tinyalu_param.sv
// ============================================================================
// Module      : tinyalu_param
// Description : Parametrised ALU, single-cycle logic/arith ops plus a
//               MULT_STAGES-latency multiplier behind a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tinyalu_param #(
    parameter int WIDTH       = 8,
    parameter int MULT_STAGES = 3
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    tinyalu_param_if.slave bus
);
    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;
    localparam logic [2:0] c_OP_SUB = 3'b101;
    localparam logic [2:0] c_OP_OR  = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0] r_a,      w_a_nxt;
    logic [WIDTH-1:0] r_b,      w_b_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_err,    w_err_nxt;
    logic [RW-1:0]    r_result, w_result_nxt;

    logic [RW-1:0]    w_a_ext;
    logic [RW-1:0]    w_b_ext;
    logic [RW-1:0]    w_prod_held;
    logic             w_accept;

    // Operands are zero-extended first so sums, products and differences
    // are formed at full 2*WIDTH precision; SUB wraps within 2*WIDTH.
    assign w_a_ext     = {{WIDTH{1'b0}}, bus.A};
    assign w_b_ext     = {{WIDTH{1'b0}}, bus.B};
    assign w_prod_held = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_accept    = bus.start && (r_state == S_IDLE) && (bus.op != c_OP_NOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_result_nxt = r_result;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_done_nxt = 1'b1;
                    case (bus.op)
                        c_OP_ADD: w_result_nxt = w_a_ext + w_b_ext;
                        c_OP_AND: w_result_nxt = w_a_ext & w_b_ext;
                        c_OP_XOR: w_result_nxt = w_a_ext ^ w_b_ext;
                        c_OP_SUB: w_result_nxt = w_a_ext - w_b_ext;
                        c_OP_OR:  w_result_nxt = w_a_ext | w_b_ext;
                        c_OP_MUL: begin
                            if (MULT_STAGES == 1) begin
                                w_result_nxt = w_a_ext * w_b_ext;
                            end else begin
                                w_done_nxt  = 1'b0;
                                w_state_nxt = S_MUL;
                                w_cnt_nxt   = CNT_W'(MULT_STAGES - 1);
                                w_a_nxt     = bus.A;
                                w_b_nxt     = bus.B;
                            end
                        end
                        default:  w_err_nxt = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = S_IDLE;
                    w_done_nxt   = 1'b1;
                    w_result_nxt = w_prod_held;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy   = (r_state == S_MUL);
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;
endmodule

`default_nettype wire

// File: tb/tb_tinyalu_param.sv
// ============================================================================
// Module      : tb_tinyalu_param
// Description : Self-checking bench: directed plan plus random traffic against
//               a transaction-level reference model (8-bit), 16-bit MUL run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tinyalu_param;
    localparam int MS8  = 3;
    localparam int MS16 = 5;

    logic clk = 1'b0;
    logic rst8_n;
    logic rst16_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    tinyalu_param_if #(.WIDTH(8))  bus8 ();
    tinyalu_param_if #(.WIDTH(16)) bus16 ();

    tinyalu_param #(.WIDTH(8), .MULT_STAGES(MS8)) dut8 (
        .clk     (clk),
        .reset_n (rst8_n),
        .bus     (bus8)
    );

    tinyalu_param #(.WIDTH(16), .MULT_STAGES(MS16)) dut16 (
        .clk     (clk),
        .reset_n (rst16_n),
        .bus     (bus16)
    );

    // Reference model state for the 8-bit instance
    logic   m_busy     = 1'b0;
    logic   m_done     = 1'b0;
    logic   m_err      = 1'b0;
    longint m_result   = 0;
    longint m_prod     = 0;
    int     m_mul_left = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint ref_op(input logic [2:0] o, input longint a, input longint b);
        longint mask;
        mask = (longint'(1) << 16) - 1;
        case (o)
            3'd1:    return a + b;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            3'd4:    return a * b;
            3'd5:    return (a - b) & mask;
            3'd6:    return a | b;
            default: return 0;
        endcase
    endfunction

    task automatic step8(input logic s, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic acc;
        @(negedge clk);
        bus8.start = s;
        bus8.op    = o;
        bus8.A     = a;
        bus8.B     = b;
        @(posedge clk);
        acc    = s && !m_busy && (o != 3'd0);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                m_done   = 1'b1;
                m_result = m_prod;
            end
        end
        if (acc) begin
            if (o == 3'd4 && MS8 > 1) begin
                m_mul_left = MS8;
                m_prod     = longint'(a) * longint'(b);
            end else if (o == 3'd7) begin
                m_done = 1'b1;
                m_err  = 1'b1;
            end else begin
                m_done   = 1'b1;
                m_result = ref_op(o, longint'(a), longint'(b));
            end
        end
        m_busy = (m_mul_left > 0);
        #1;
        check_eq("busy8",   64'(bus8.busy),   64'(m_busy));
        check_eq("done8",   64'(bus8.done),   64'(m_done));
        check_eq("err8",    64'(bus8.err),    64'(m_err));
        check_eq("result8", 64'(bus8.result), 64'(m_result));
    endtask

    task automatic step16(input logic s, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus16.start = s;
        bus16.op    = o;
        bus16.A     = a;
        bus16.B     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dones;
        rst8_n      = 1'b0;
        rst16_n     = 1'b0;
        bus8.start  = 1'b0;  bus8.op  = 3'd0; bus8.A  = '0; bus8.B  = '0;
        bus16.start = 1'b0;  bus16.op = 3'd0; bus16.A = '0; bus16.B = '0;
        repeat (2) @(negedge clk);
        rst8_n  = 1'b1;
        rst16_n = 1'b1;
        #1;
        check_eq("rst_busy",   64'(bus8.busy),   64'd0);
        check_eq("rst_done",   64'(bus8.done),   64'd0);
        check_eq("rst_err",    64'(bus8.err),    64'd0);
        check_eq("rst_result", 64'(bus8.result), 64'd0);

        // ADD with carry into bit WIDTH
        step8(1'b1, 3'd1, 8'hFF, 8'h01);
        check_eq("add_result", 64'(bus8.result), 64'h0100);
        check_eq("add_done",   64'(bus8.done),   64'd1);
        step8(1'b0, 3'd0, 8'h00, 8'h00);
        check_eq("add_done_low", 64'(bus8.done), 64'd0);

        // MUL with operands changed after accept, ignored start while busy
        step8(1'b1, 3'd4, 8'd200, 8'd150);
        check_eq("mul_busy1", 64'(bus8.busy), 64'd1);
        step8(1'b1, 3'd1, 8'd7, 8'd7);
        check_eq("mul_busy2", 64'(bus8.busy), 64'd1);
        step8(1'b0, 3'd0, 8'd1, 8'd1);
        check_eq("mul_busy3", 64'(bus8.busy), 64'd1);
        step8(1'b0, 3'd0, 8'd0, 8'd0);
        check_eq("mul_done",   64'(bus8.done),   64'd1);
        check_eq("mul_result", 64'(bus8.result), 64'd30000);
        step8(1'b1, 3'd5, 8'd3, 8'd5);
        check_eq("sub_result", 64'(bus8.result), 64'hFFFE);

        // Streaming logic ops
        step8(1'b1, 3'd2, 8'hF0, 8'h3C);
        check_eq("and_result", 64'(bus8.result), 64'h0030);
        step8(1'b1, 3'd3, 8'hF0, 8'h3C);
        check_eq("xor_result", 64'(bus8.result), 64'h00CC);
        step8(1'b1, 3'd6, 8'hF0, 8'h3C);
        check_eq("or_result",  64'(bus8.result), 64'h00FC);
        step8(1'b1, 3'd2, 8'hF0, 8'h3C);
        check_eq("and2_result", 64'(bus8.result), 64'h0030);

        // Illegal op keeps result; NOP produces nothing
        step8(1'b1, 3'd7, 8'h12, 8'h34);
        check_eq("ill_err",    64'(bus8.err),    64'd1);
        check_eq("ill_result", 64'(bus8.result), 64'h0030);
        step8(1'b1, 3'd0, 8'h12, 8'h34);
        check_eq("nop_done",   64'(bus8.done),   64'd0);

        // Asynchronous reset while a MUL is in flight
        step8(1'b1, 3'd4, 8'd9, 8'd9);
        #2;
        bus8.start = 1'b0;
        rst8_n     = 1'b0;
        #1;
        check_eq("arst_busy",   64'(bus8.busy),   64'd0);
        check_eq("arst_result", 64'(bus8.result), 64'd0);
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_result = 0; m_mul_left = 0;
        @(negedge clk);
        rst8_n = 1'b1;
        dones  = 0;
        for (int i = 0; i < 5; i++) begin
            step8(1'b0, 3'd4, 8'd9, 8'd9);
            dones += int'(bus8.done);
        end
        check_eq("arst_no_done", 64'(dones), 64'd0);
        step8(1'b1, 3'd1, 8'd20, 8'd22);
        check_eq("arst_first", 64'(bus8.result), 64'd42);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step8(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end

        // 16-bit instance, 5-stage multiplier
        check_eq("w16_rst_result", 64'(bus16.result), 64'd0);
        step16(1'b1, 3'd4, 16'hFFFF, 16'hFFFF);
        check_eq("w16_busy0", 64'(bus16.busy), 64'd1);
        for (int i = 0; i < MS16 - 1; i++) begin
            step16(1'b0, 3'd0, 16'h0000, 16'h0000);
            check_eq("w16_busy", 64'({bus16.busy, bus16.done}), 64'b10);
        end
        step16(1'b0, 3'd0, 16'h0000, 16'h0000);
        check_eq("w16_done",   64'({bus16.busy, bus16.done, bus16.err}), 64'b010);
        check_eq("w16_result", 64'(bus16.result), 64'hFFFE0001);
        step16(1'b1, 3'd1, 16'hFFFF, 16'hFFFF);
        check_eq("w16_add", 64'(bus16.result), 64'h0001FFFE);
        step16(1'b1, 3'd5, 16'h0000, 16'h0001);
        check_eq("w16_sub", 64'(bus16.result), 64'hFFFFFFFF);
        step16(1'b0, 3'd0, 16'h0000, 16'h0000);
        check_eq("w16_idle", 64'(bus16.done), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
